// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from EX, drives a single-beat request/grant bus and
// returns sign/zero-extended load data for one cycle.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ex_valid_i               EX result valid this cycle
//   mem_read_i, mem_write_i  op controls (both high -> store)
//   funct3_i                 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i                   byte address
//   store_data_i             rs2 value
//   rd_i                     load destination register
//   bus_req_o/we_o/addr_o/be_o/wdata_o   request side, held stable until bus_gnt_i
//   bus_gnt_i, bus_rdata_i, bus_rvalid_i response side
//   stall_o                  hold upstream while the op is in flight
//   wb_valid_o/rd_o/data_o   one-cycle load writeback
//   misaligned_o             one-cycle fault pulse, no bus activity
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_rvalid_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] sdata_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;

  logic        accept;
  logic        fault;
  logic        start;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rshift;
  logic [31:0] load_ext;

  assign accept = (state_q == StIdle) && ex_valid_i && (mem_read_i || mem_write_i);

  // Illegal encodings, misaligned halfword/word, and unsigned stores all fault.
  always_comb begin
    fault = 1'b1;
    case (funct3_i)
      3'b000:  fault = 1'b0;
      3'b001:  fault = addr_i[0];
      3'b010:  fault = |addr_i[1:0];
      3'b100:  fault = mem_write_i;
      3'b101:  fault = mem_write_i | addr_i[0];
      default: fault = 1'b1;
    endcase
  end

  assign start = accept && !fault;

  // Lane steering from the latched op; legal accesses never cross the word.
  always_comb begin
    be    = 4'b1111;
    wdata = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_q[1:0];
        wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    rshift   = bus_rdata_i >> {addr_q[1:0], 3'b000};
    load_ext = rshift;
    case (funct3_q)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_ext = {24'h0, rshift[7:0]};
      3'b101:  load_ext = {16'h0, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= 32'h0;
      funct3_q     <= 3'b000;
      sdata_q      <= 32'h0;
      rd_q         <= 5'd0;
      we_q         <= 1'b0;
      wb_data_q    <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (fault) begin
              misaligned_q <= 1'b1;
            end else begin
              state_q  <= StReq;
              addr_q   <= addr_i;
              funct3_q <= funct3_i;
              sdata_q  <= store_data_i;
              rd_q     <= rd_i;
              we_q     <= mem_write_i;
            end
          end
        end
        StReq: begin
          if (bus_gnt_i) state_q <= we_q ? StDone : StWait;
        end
        StWait: begin
          if (bus_rvalid_i) begin
            wb_data_q <= load_ext;
            state_q   <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only, except stall which must rise in the accept cycle.
  // Gating with rst_ni keeps stall low while reset is held even if ex_valid is high.
  always_comb begin
    stall_o      = rst_ni && (start || (state_q == StReq) || (state_q == StWait));
    bus_req_o    = (state_q == StReq);
    bus_we_o     = (state_q == StReq) && we_q;
    bus_addr_o   = (state_q == StReq) ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_be_o     = (state_q == StReq) ? be : 4'b0000;
    bus_wdata_o  = ((state_q == StReq) && we_q) ? wdata : 32'h0;
    wb_valid_o   = (state_q == StDone) && !we_q;
    wb_rd_o      = ((state_q == StDone) && !we_q) ? rd_q : 5'd0;
    wb_data_o    = ((state_q == StDone) && !we_q) ? wb_data_q : 32'h0;
    misaligned_o = misaligned_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_valid_i   (ex_valid),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .rd_i         (rd_in),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_be_o     (bus_be),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rdata_i  (bus_rdata),
    .bus_rvalid_i (bus_rvalid),
    .stall_o      (stall),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .misaligned_o (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for an illegal encoding.
  function automatic int op_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit op_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    if (sz == 0) return 0;
    if ((a % sz) != 0) return 0;
    if (wr && (sz < 4) && (f3 >= 3'd4)) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    int off = int'(a % 4);
    logic [3:0] r = 4'b0000;
    for (int k = 0; k < 4; k++) if (k >= off && k < off + sz) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = op_size(f3);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) r = r | (((sd >> (8 * (k % sz))) & 32'hFF) << (8 * k));
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    int sz = op_size(f3);
    int bits = 8 * sz;
    logic [63:0] v = 64'(rdata) >> (8 * (a % 4));
    v = v & ((64'd1 << bits) - 64'd1);
    if (f3 < 3'd4 && sz < 4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // One complete op: accept cycle, gdly extra REQ cycles, rdly extra WAIT cycles, then DONE.
  task automatic do_op(input string tag, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int gdly, input int rdly);
    bit legal = op_legal(wr, f3, a);
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = !wr; mem_write = wr; funct3 = f3; addr = a;
    store_data = sd; rd_in = rd; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s stall@accept", tag), stall, legal);
    chk($sformatf("%s req@accept", tag), bus_req, 0);
    chk($sformatf("%s wbv@accept", tag), wb_valid, 0);
    chk($sformatf("%s mis@accept", tag), misaligned, 0);
    if (!legal) begin
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("%s mis pulse", tag), misaligned, 1);
      chk($sformatf("%s mis stall", tag), stall, 0);
      chk($sformatf("%s mis req", tag), bus_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("%s mis end", tag), misaligned, 0);
      chk($sformatf("%s mis req2", tag), bus_req, 0);
      return;
    end
    for (int i = 0; i <= gdly; i++) begin
      @(posedge clk); #1;
      bus_gnt = (i == gdly);
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("%s req", tag), bus_req, 1);
      chk($sformatf("%s we", tag), bus_we, wr);
      chk($sformatf("%s addr", tag), bus_addr, {a[31:2], 2'b00});
      chk($sformatf("%s be", tag), bus_be, exp_be(f3, a));
      chk($sformatf("%s wdata", tag), bus_wdata, wr ? exp_wdata(f3, sd) : 32'h0);
      chk($sformatf("%s stall@req", tag), stall, 1);
      chk($sformatf("%s wbv@req", tag), wb_valid, 0);
    end
    if (!wr) begin
      for (int j = 0; j <= rdly; j++) begin
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        bus_rvalid = (j == rdly);
        bus_rdata = (j == rdly) ? rdata : $urandom;
        @(negedge clk);
        chk($sformatf("%s req@wait", tag), bus_req, 0);
        chk($sformatf("%s stall@wait", tag), stall, 1);
        chk($sformatf("%s wbv@wait", tag), wb_valid, 0);
      end
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0;
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(negedge clk);
    chk($sformatf("%s wb_valid", tag), wb_valid, !wr);
    chk($sformatf("%s wb_rd", tag), wb_rd, wr ? 5'd0 : rd);
    chk($sformatf("%s wb_data", tag), wb_data, wr ? 32'h0 : exp_load(f3, a, rdata));
    chk($sformatf("%s stall@done", tag), stall, 0);
    chk($sformatf("%s req@done", tag), bus_req, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; rd_in = 5'd0; bus_gnt = 1'b0; bus_rdata = 32'h0;
    bus_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset req", bus_req, 0);
    chk("reset wbv", wb_valid, 0);
    chk("reset mis", misaligned, 0);
    chk("reset addr", bus_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("SW", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 0);
    do_op("SB", 1'b1, 3'b000, 32'h101, 32'h000000AB, 5'd2, 32'h0, 0, 0);
    do_op("LB", 1'b0, 3'b000, 32'h203, 32'h0, 5'd5, 32'h80FF1234, 0, 0);
    do_op("LBU", 1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 32'h80FF1234, 0, 0);
    do_op("LH", 1'b0, 3'b001, 32'h202, 32'h0, 5'd7, 32'h80010000, 3, 1);
    do_op("LW mis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd8, 32'h0, 0, 0);
    do_op("SBU ill", 1'b1, 3'b100, 32'h100, 32'h55, 5'd8, 32'h0, 0, 0);
    do_op("F3 ill", 1'b0, 3'b011, 32'h100, 32'h0, 5'd8, 32'h0, 0, 0);
    do_op("LW rd0", 1'b0, 3'b010, 32'h104, 32'h0, 5'd0, 32'hCAFEF00D, 1, 0);

    // Abandon a load in WAIT with an asynchronous reset.
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h400;
    rd_in = 5'd9;
    @(negedge clk);
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("rst req", bus_req, 1);
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("rst wait stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async stall", stall, 0);
    chk("rst async req", bus_req, 0);
    chk("rst async wbv", wb_valid, 0);
    chk("rst async addr", bus_addr, 0);
    ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray rvalid wbv", wb_valid, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stray rvalid wbv2", wb_valid, 0);
    chk("stray rvalid stall", stall, 0);
    do_op("LW post", 1'b0, 3'b010, 32'h300, 32'h0, 5'd10, 32'h12345678, 0, 0);

    for (int n = 0; n < 40; n++) begin
      bit          wr   = 1'($urandom_range(0, 1));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom;
      logic [31:0] sd   = $urandom;
      logic [4:0]  rd   = 5'($urandom_range(0, 31));
      logic [31:0] rdat = $urandom;
      do_op($sformatf("rnd%0d", n), wr, f3, a, sd, rd, rdat,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
